// File: rtl/uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// uart_rx_fifo
//   Asynchronous serial receiver for the FPGA host link. It frames start,
//   DATA_BITS data bits (LSB first), an optional parity bit and a stop bit.
//   Each bit is sampled at its middle. Good words go into a small receive
//   FIFO, so the line keeps running while the command decoder is busy.
//
//   Optional feature macro: UART_RX_PARITY_EN
//     defined   : a parity bit follows the data bits; parity_err_o is live
//                 (PARITY_ODD selects odd (1) or even (0) parity).
//     undefined : no parity bit; parity_err_o is tied low.
//
// Ports
//   clk_i          system clock
//   nrst_i         asynchronous active-low reset
//   rx_i           serial input, idle high, asynchronous to clk_i
//   rts_o          1 = sender must pause (still qualifying idle, or FIFO nearly full)
//   data_o         FIFO head word, valid while data_valid_o = 1
//   data_valid_o   FIFO not empty
//   data_ack_n_i   active-low pop, honoured on any edge where data_valid_o = 1
//   framing_err_o  1-cycle pulse: stop bit sampled low
//   overrun_err_o  1-cycle pulse: good word dropped because the FIFO was full
//   parity_err_o   1-cycle pulse: parity mismatch (tied low without the macro)
// ----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 32,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int IDLE_BITS    = 9,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk_i,
    input  logic                 nrst_i,
    input  logic                 rx_i,
    output logic                 rts_o,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 data_valid_o,
    input  logic                 data_ack_n_i,
    output logic                 framing_err_o,
    output logic                 overrun_err_o,
    output logic                 parity_err_o
);

    localparam int IDLE_CYCLES = IDLE_BITS * CLKS_PER_BIT;
    localparam int CNT_W       = $clog2(IDLE_CYCLES + 1);
    localparam int IDX_W       = $clog2(DATA_BITS + 1);
    localparam int PTR_W       = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST   = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_BIT    = IDX_W'(DATA_BITS - 1);
    localparam logic [PTR_W:0]   FULL_LEVEL  = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   RTS_LEVEL   = (PTR_W + 1)'(FIFO_DEPTH - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} rxState_e;
`else
    typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_START, ST_DATA, ST_STOP} rxState_e;
`endif

    rxState_e               state_q, state_d;
    logic                   rxMeta_q, rxSync_q;
    logic [CNT_W-1:0]       bitCnt_q, bitCnt_d;
    logic [IDX_W-1:0]       bitIdx_q, bitIdx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [PTR_W:0]         wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d, count_d;
    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   dataValid_q, dataValid_d;
    logic                   rts_q, rts_d;
    logic                   framingErr_q, framingErr_d;
    logic                   overrunErr_q, overrunErr_d;
    logic                   stopSample, wordOk, push, pop, fifoFull, parityBad;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
        end else begin
            rxMeta_q <= rx_i;
            rxSync_q <= rxMeta_q;
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. In INIT the counter counts up consecutive high
    // cycles; in every other state it counts down to the next sample point.
    always_comb begin
        state_d  = state_q;
        bitCnt_d = bitCnt_q;
        bitIdx_d = bitIdx_q;
        shift_d  = shift_q;
        unique case (state_q)
            ST_INIT: begin
                if (!rxSync_q) begin
                    bitCnt_d = '0;
                end else if (bitCnt_q == IDLE_LAST) begin
                    bitCnt_d = '0;
                    state_d  = ST_IDLE;
                end else begin
                    bitCnt_d = bitCnt_q + CNT_W'(1);
                end
            end
            ST_IDLE: begin
                if (!rxSync_q) begin
                    bitCnt_d = HALF_RELOAD;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (bitCnt_q != '0) begin
                    bitCnt_d = bitCnt_q - CNT_W'(1);
                end else if (rxSync_q) begin
                    state_d = ST_IDLE;
                end else begin
                    bitCnt_d = BIT_RELOAD;
                    bitIdx_d = '0;
                    state_d  = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bitCnt_q != '0) begin
                    bitCnt_d = bitCnt_q - CNT_W'(1);
                end else begin
                    shift_d  = {rxSync_q, shift_q[DATA_BITS-1:1]};
                    bitCnt_d = BIT_RELOAD;
                    bitIdx_d = bitIdx_q + IDX_W'(1);
                    if (bitIdx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (bitCnt_q != '0) begin
                    bitCnt_d = bitCnt_q - CNT_W'(1);
                end else begin
                    bitCnt_d = BIT_RELOAD;
                    state_d  = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bitCnt_q != '0) begin
                    bitCnt_d = bitCnt_q - CNT_W'(1);
                end else begin
                    bitCnt_d = '0;
                    state_d  = rxSync_q ? ST_IDLE : ST_INIT;
                end
            end
            default: begin
                bitCnt_d = '0;
                state_d  = ST_INIT;
            end
        endcase
    end

`ifdef UART_RX_PARITY_EN
    logic parBit_q;

    // Captures the parity bit at its mid-bit sample.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            parBit_q <= 1'b0;
        end else if (state_q == ST_PARITY && bitCnt_q == '0) begin
            parBit_q <= rxSync_q;
        end
    end

    // XOR of data and parity bit must equal 1 for odd parity, 0 for even.
    assign parityBad = ((^shift_q) ^ parBit_q) != 1'(PARITY_ODD);
`else
    assign parityBad = 1'b0;
`endif

    assign pop      = !data_ack_n_i && dataValid_q;
    assign fifoFull = (wrPtr_q - rdPtr_q) == FULL_LEVEL;

    // FSM outputs, all decided at the stop-bit sample. A concurrent pop
    // frees a slot, so a full FIFO with a pop still accepts the word.
    always_comb begin
        stopSample   = (state_q == ST_STOP) && (bitCnt_q == '0);
        framingErr_d = stopSample && !rxSync_q;
        wordOk       = stopSample && rxSync_q && !parityBad;
        push         = wordOk && (!fifoFull || pop);
        overrunErr_d = wordOk && fifoFull && !pop;
    end

    // FIFO next state. If the new head is the slot being written this
    // cycle, the incoming word is forwarded straight to the output register.
    always_comb begin
        wrPtr_d     = wrPtr_q + (PTR_W + 1)'(push);
        rdPtr_d     = rdPtr_q + (PTR_W + 1)'(pop);
        count_d     = wrPtr_d - rdPtr_d;
        dataValid_d = (count_d != '0);
        data_d      = '0;
        if (dataValid_d) begin
            if (push && (wrPtr_q[PTR_W-1:0] == rdPtr_d[PTR_W-1:0])) begin
                data_d = shift_q;
            end else begin
                data_d = mem[rdPtr_d[PTR_W-1:0]];
            end
        end
        rts_d = (state_d == ST_INIT) || (count_d >= RTS_LEVEL);
    end

    // FIFO storage; contents are only read behind a valid pointer.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wrPtr_q[PTR_W-1:0]] <= shift_q;
        end
    end

    // Datapath, FIFO pointers and registered outputs.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            bitCnt_q     <= '0;
            bitIdx_q     <= '0;
            shift_q      <= '0;
            wrPtr_q      <= '0;
            rdPtr_q      <= '0;
            data_q       <= '0;
            dataValid_q  <= 1'b0;
            rts_q        <= 1'b1;
            framingErr_q <= 1'b0;
            overrunErr_q <= 1'b0;
        end else begin
            bitCnt_q     <= bitCnt_d;
            bitIdx_q     <= bitIdx_d;
            shift_q      <= shift_d;
            wrPtr_q      <= wrPtr_d;
            rdPtr_q      <= rdPtr_d;
            data_q       <= data_d;
            dataValid_q  <= dataValid_d;
            rts_q        <= rts_d;
            framingErr_q <= framingErr_d;
            overrunErr_q <= overrunErr_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parityErr_q;

    // Parity error pulse, registered like the other error pulses.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            parityErr_q <= 1'b0;
        end else begin
            parityErr_q <= stopSample && rxSync_q && parityBad;
        end
    end

    assign parity_err_o = parityErr_q;
`else
    assign parity_err_o = 1'b0;
`endif

    assign rts_o         = rts_q;
    assign data_o        = data_q;
    assign data_valid_o  = dataValid_q;
    assign framing_err_o = framingErr_q;
    assign overrun_err_o = overrunErr_q;

endmodule
